// File: rtl/ysyx_25020037_lsu_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020037_lsu_axi_pkg
// Purpose  : Shared encodings for the AXI4-Lite load/store unit: access sizes,
//            fault cause codes, AXI response codes, FSM state type and small
//            size-decoding helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25020037_lsu_axi_pkg;

    // Access size encodings carried on in_size
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    // Fault cause codes reported on out_cause
    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_BUS      = 2'd2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_t;

    // Address low bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_low_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SIZE_B:  m = 3'b000;
            SIZE_H:  m = 3'b001;
            SIZE_W:  m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    // Byte-enable pattern of an access before lane shifting
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SIZE_B:  m = 8'h01;
            SIZE_H:  m = 8'h03;
            SIZE_W:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25020037_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020037_lsu_align
// Purpose  : Combinational byte-lane logic for the LSU.
//            Store: replicate data across lanes, build write strobes.
//            Load : extract the addressed lane and sign/zero extend it.
//            Also flags misaligned accesses (or forces alignment when
//            checking is disabled).
// Ports    : size/is_unsigned/addr   - access descriptor
//            st_data / rdata         - LSB-aligned store data / raw bus data
//            bus_addr                - address to present on the bus
//            misaligned              - access violates natural alignment
//            wdata / wstrb           - steered store data and strobes
//            ld_data                 - extended load result
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020037_lsu_align
    import ysyx_25020037_lsu_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                misaligned,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   ld_data
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [2:0]        low_mask;
    logic [OFF_W-1:0]  offset;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] keep_mask;
    logic              sign_bit;

    assign low_mask   = size_low_mask(size);
    assign misaligned = (CHECK_ALIGN != 0) && ((addr[2:0] & low_mask) != 3'd0);

    // With checking disabled the low address bits are simply cleared, so the
    // access always lands on its natural boundary.
    assign bus_addr = (CHECK_ALIGN != 0) ? addr : (addr & ~ADDR_W'(low_mask));
    assign offset   = bus_addr[OFF_W-1:0];

    always_comb begin
        wdata = st_data;
        case (size)
            SIZE_B:  wdata = {NB{st_data[7:0]}};
            SIZE_H:  wdata = {(NB/2){st_data[15:0]}};
            SIZE_W:  wdata = {(DATA_W/32){st_data[31:0]}};
            default: wdata = st_data;
        endcase
    end

    // Truncation to NB bits discards lanes beyond the bus width.
    assign wstrb = NB'(size_byte_mask(size)) << offset;

    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size)
            SIZE_B: begin
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = lane[7];
            end
            SIZE_H: begin
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = lane[15];
            end
            SIZE_W: begin
                keep_mask = DATA_W'(32'hFFFF_FFFF);
                sign_bit  = lane[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = 1'b0;
            end
        endcase
    end

    assign ld_data = (lane & keep_mask) | ({DATA_W{sign_bit & ~is_unsigned}} & ~keep_mask);

endmodule
`default_nettype wire

// File: rtl/ysyx_25020037_lsu_axi.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020037_lsu_axi
// Purpose  : Load/store unit between EXU and WBU mastering an AXI4-Lite data
//            port. One transaction in flight; faults are reported to the WBU.
// Ports    : in_*   - EXU request handshake and operands
//            out_*  - WBU result handshake, data and fault status
//            aw/w/b/ar/r* - AXI4-Lite master channels
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020037_lsu_axi
    import ysyx_25020037_lsu_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CHECK_ALIGN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_ld,
    input  logic                in_st,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    input  logic [DATA_W-1:0]   in_result,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_fault,
    output logic [1:0]          out_cause,
    output logic                out_is_store,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready
);

    lsu_state_t state, state_next;

    logic [1:0]          r_size;
    logic                r_unsigned;

    logic [1:0]          al_size;
    logic [ADDR_W-1:0]   al_addr;
    logic [ADDR_W-1:0]   al_bus_addr;
    logic                al_misaligned;
    logic [DATA_W-1:0]   al_wdata;
    logic [DATA_W/8-1:0] al_wstrb;
    logic [DATA_W-1:0]   al_ld_data;

    logic                mem_op;
    logic                aw_ok;
    logic                w_ok;

    // In IDLE the aligner sees the incoming request; afterwards it sees the
    // captured load descriptor (araddr already holds the bus address).
    assign al_size = (state == ST_IDLE) ? in_size : r_size;
    assign al_addr = (state == ST_IDLE) ? in_addr : araddr;

    ysyx_25020037_lsu_align #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .CHECK_ALIGN (CHECK_ALIGN)
    ) u_align (
        .size        (al_size),
        .is_unsigned (r_unsigned),
        .addr        (al_addr),
        .st_data     (in_wdata),
        .rdata       (rdata),
        .bus_addr    (al_bus_addr),
        .misaligned  (al_misaligned),
        .wdata       (al_wdata),
        .wstrb       (al_wstrb),
        .ld_data     (al_ld_data)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign mem_op    = in_ld | in_st;

    // A write channel is finished once its valid has dropped or is being
    // accepted this cycle; AW and W complete independently.
    assign aw_ok = ~awvalid | awready;
    assign w_ok  = ~wvalid  | wready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_op && al_misaligned) state_next = ST_DONE;
                    else if (in_ld)              state_next = ST_RADDR;
                    else if (in_st)              state_next = ST_WREQ;
                    else                         state_next = ST_DONE;
                end
            end
            ST_RADDR: if (arready)       state_next = ST_RDATA;
            ST_RDATA: if (rvalid)        state_next = ST_DONE;
            ST_WREQ:  if (aw_ok && w_ok) state_next = ST_WRESP;
            ST_WRESP: if (bvalid)        state_next = ST_DONE;
            ST_DONE:  if (out_ready)     state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size       <= SIZE_B;
            r_unsigned   <= 1'b0;
            araddr       <= '0;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awaddr       <= '0;
            awvalid      <= 1'b0;
            wdata        <= '0;
            wstrb        <= '0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            out_data     <= '0;
            out_fault    <= 1'b0;
            out_cause    <= CAUSE_NONE;
            out_is_store <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_size       <= in_size;
                        r_unsigned   <= in_unsigned;
                        out_is_store <= in_st;
                        out_fault    <= 1'b0;
                        out_cause    <= CAUSE_NONE;
                        if (mem_op && al_misaligned) begin
                            out_fault <= 1'b1;
                            out_cause <= CAUSE_MISALIGN;
                            out_data  <= '0;
                        end else if (in_ld) begin
                            araddr  <= al_bus_addr;
                            arvalid <= 1'b1;
                        end else if (in_st) begin
                            awaddr  <= al_bus_addr;
                            wdata   <= al_wdata;
                            wstrb   <= al_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            out_data <= in_result;
                        end
                    end
                end
                ST_RADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (rvalid) begin
                        rready <= 1'b0;
                        if (rresp != RESP_OKAY) begin
                            out_fault <= 1'b1;
                            out_cause <= CAUSE_BUS;
                            out_data  <= '0;
                        end else begin
                            out_data <= al_ld_data;
                        end
                    end
                end
                ST_WREQ: begin
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if (aw_ok && w_ok) bready <= 1'b1;
                end
                ST_WRESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != RESP_OKAY) begin
                            out_fault <= 1'b1;
                            out_cause <= CAUSE_BUS;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
